// File: rtl/instruction_fetch.sv
// Fetch stage: issues credit-limited imem requests, buffers in-order responses and
// presents {instr, pc} to decode; a redirect flushes the buffer and drops stale responses.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_WIDE = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  fetch_entry_t  mem_q [FIFO_DEPTH];

  logic        req_fire, rsp_ok, push, pop;
  logic [CW:0] credits_used;
  logic [31:0] target_pc;
  logic        unused_pc_lsbs;

  assign target_pc      = {redirect_pc[31:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Words already buffered and requests still in flight (including ones to be dropped) share the credit pool.
  assign credits_used   = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && !redirect_valid && (credits_used < DEPTH_WIDE);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_ok   = imem_rsp_valid && (inflight_q != '0);
  assign push     = rsp_ok && (drop_cnt_q == '0) && !redirect_valid;
  assign id_valid = (count_q != '0);
  assign pop      = id_valid && id_ready && !redirect_valid;
  assign id_instr = id_valid ? mem_q[rd_ptr_q].instr : '0;
  assign id_pc    = id_valid ? mem_q[rd_ptr_q].pc    : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_cnt_d = drop_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
    count_d    = count_q + CW'(push) - CW'(pop);
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (rsp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    // Every request still outstanding after this cycle belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      drop_cnt_d = inflight_q - CW'(rsp_ok);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: imem_rsp_data, pc: rsp_pc_q};
  end

`ifndef SYNTHESIS
  rsp_without_request: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (inflight_q == '0)));
  push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == DEPTH_CNT)));
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: pipelined memory model plus a stream-level scoreboard.
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  typedef struct {
    logic [31:0] target;
    logic [31:0] first_pc;
    logic [31:0] second_pc;
  } redir_vec_t;

  int n_tests = 0, n_fail = 0, cyc = 0, n_pops = 0;
  int rdy_pct = 100, req_rdy_pct = 100, lat_min = 1, lat_max = 1;

  // Memory model: outstanding requests in issue order; stale ones belong to a squashed path.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  bit          mq_stale[$];
  int          last_due = 0;

  int          model_cnt;
  logic [31:0] exp_pc, exp_req;
  bit          redir_prev, pop_seen;
  logic [31:0] pop_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic model_reset();
    mq_addr.delete(); mq_due.delete(); mq_stale.delete();
    last_due = 0; model_cnt = 0; redir_prev = 0; pop_seen = 0;
    exp_pc = RESET_PC; exp_req = RESET_PC;
  endtask

  // One clock cycle: called at a falling edge, drives inputs, checks, returns at the next falling edge.
  task automatic cycle(input bit redir, input logic [31:0] tgt);
    int outs, due;
    bit rstale, fire;
    outs           = mq_addr.size();
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : $urandom();
    id_ready       = (int'($urandom_range(99)) < rdy_pct);
    imem_req_ready = (int'($urandom_range(99)) < req_rdy_pct);
    rstale = 0;
    if (outs != 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mq_addr[0]);
      rstale         = mq_stale[0];
      void'(mq_addr.pop_front()); void'(mq_due.pop_front()); void'(mq_stale.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    #1;
    chk_b("id_valid", id_valid, model_cnt != 0);
    if (redir_prev) chk_b("id_valid_after_redirect", id_valid, 1'b0);
    chk_b("req_valid_credit", imem_req_valid, !redir && (outs + model_cnt < DEPTH));
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
    if (id_valid) begin
      chk("id_pc", id_pc, exp_pc);
      chk("id_instr", id_instr, word_of(exp_pc));
    end
    fire     = imem_req_valid && imem_req_ready;
    pop_seen = 0;
    if (id_valid && id_ready && !redir) begin
      pop_seen = 1; pop_pc = id_pc; exp_pc += 32'd4; model_cnt--; n_pops++;
    end
    if (imem_rsp_valid && !rstale && !redir) model_cnt++;
    if (redir) begin
      model_cnt = 0;
      foreach (mq_stale[i]) mq_stale[i] = 1'b1;
      exp_pc  = {tgt[31:2], 2'b00};
      exp_req = {tgt[31:2], 2'b00};
    end
    if (fire) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(imem_req_addr); mq_due.push_back(due); mq_stale.push_back(1'b0);
      exp_req += 32'd4;
    end
    redir_prev = redir;
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(1'b0, 32'h0);
      got = pop_seen;
    end
    if (got) chk(name, pop_pc, exp);
    else begin
      n_tests++; n_fail++;
      $display("FAIL %s: no decode handshake within 40 cycles, expected pc %h", name, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_b({tag, "_req_valid"}, imem_req_valid, 1'b0);
    chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    chk_b({tag, "_id_valid"}, id_valid, 1'b0);
    chk({tag, "_id_instr"}, id_instr, 32'h0);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
  endtask

  initial begin
    redir_vec_t vecs[4];
    bit found;
    int pops_before;
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h1000_0007, 32'h1000_0004, 32'h1000_0008};

    rst = 1'b1; redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");

    // Stall decode from the very first cycle: buffer fills, then credits stop requests.
    @(negedge clk);
    rst = 1'b0; rdy_pct = 0;
    #1;
    chk_b("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    repeat (10) cycle(1'b0, 32'h0);
    chk_b("stall_req_valid", imem_req_valid, 1'b0);
    chk_b("stall_id_valid", id_valid, 1'b1);
    chk("stall_inflight", mq_addr.size(), 0);
    chk("stall_head_pc", id_pc, 32'h0);
    rdy_pct = 100;
    wait_pop("stall_pop0", 32'h0);
    wait_pop("stall_pop1", 32'h4);
    wait_pop("stall_pop2", 32'h8);
    repeat (20) cycle(1'b0, 32'h0);

    foreach (vecs[k]) begin
      cycle(1'b1, vecs[k].target);
      wait_pop("vec_first_pc", vecs[k].first_pc);
      wait_pop("vec_second_pc", vecs[k].second_pc);
    end

    // Redirect with two requests outstanding against a 3-cycle memory.
    lat_min = 3; lat_max = 3; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mq_addr.size() == 2) begin
        cycle(1'b1, 32'h0000_0100);
        found = 1;
      end else cycle(1'b0, 32'h0);
    end
    chk_b("two_inflight_reached", found, 1'b1);
    wait_pop("lat3_redirect_first", 32'h0000_0100);
    wait_pop("lat3_redirect_second", 32'h0000_0104);

    // Redirect coinciding with a response and a decode pop.
    lat_min = 1; lat_max = 1; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (id_valid && mq_addr.size() != 0 && mq_due[0] <= cyc) begin
        cycle(1'b1, 32'h0000_0300);
        found = 1;
      end else cycle(1'b0, 32'h0);
    end
    chk_b("coincident_case_reached", found, 1'b1);
    chk_b("coincident_flush", id_valid, 1'b0);
    wait_pop("coincident_first", 32'h0000_0300);

    // Asynchronous reset with the buffer full.
    rdy_pct = 0;
    repeat (8) cycle(1'b0, 32'h0);
    chk_b("full_before_reset", id_valid, 1'b1);
    #2 rst = 1'b1;
    imem_rsp_valid = 0; redirect_valid = 0;
    #1 chk_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_b("rerelease_req_valid", imem_req_valid, 1'b1);
    chk("rerelease_req_addr", imem_req_addr, RESET_PC);
    rdy_pct = 100;
    wait_pop("rerelease_first", RESET_PC);

    // Randomized traffic against the scoreboard.
    pops_before = n_pops;
    for (int blk = 0; blk < 6; blk++) begin
      lat_min     = 1;
      lat_max     = 1 + (blk % 3) * 2;
      rdy_pct     = int'($urandom_range(100, 40));
      req_rdy_pct = int'($urandom_range(100, 50));
      for (int i = 0; i < 500; i++)
        cycle(int'($urandom_range(99)) < 4, $urandom() & 32'h000F_FFFF);
    end
    chk_b("random_progress", (n_pops - pops_before) > 300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
